network_job_sequencer: RTL and testbench
========================================

Name: network_job_sequencer

Overview:
- Avalon-MM slave that stages the 256-bit operand vector for the runNetwork datapath, launches one evaluation per start command and waits a programmable latency.
- Captures the 128-bit result, then raises done and an optional interrupt.
- Replaces ad-hoc free-running register wrappers: operands are snapshotted at start, so software may load the next job while the current one runs.

Parameters:
- DEFAULT_LATENCY, 0, reset value of the LATENCY register (network pipeline depth in cycles).
- BLOCK_ID, 32'h4E45_5431, constant returned at address 15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- avs_s0_address  in  4  word address
- avs_s0_read  in  1  read strobe
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  32  write data
- avs_s0_readdata  out  32  read data, registered, read latency 1
- net_in  out  256  operand snapshot {a,b,c,d}, each 64 bit
- net_in_valid  out  1  one-cycle launch strobe
- net_out  in  128  network result {e,f}
- irq  out  1  done & irq_en, level

Behaviour:
- Reset (reset=0, async): operand/result/snapshot registers=0, LATENCY=DEFAULT_LATENCY, flags=0, job_count=0, state=IDLE, all outputs 0.
- Address map:
  - 0..7 operand words a_lo,a_hi,b_lo,b_hi,c_lo,c_hi,d_lo,d_hi (R/W).
  - 8 CTRL (W: bit0 start, bit1 clear_done, bit2 clear_err, bit3 irq_en; R: bit3 irq_en, other bits 0).
  - 9 STATUS (R: bit0 busy, bit1 done, bit2 overrun, [15:8] job_count).
  - 10..13 results e_lo,e_hi,f_lo,f_hi (RO).
  - 14 LATENCY (R/W, bits[7:0], upper bits read 0).
  - 15 BLOCK_ID.
- Writes to read-only or unused addresses are ignored. Reads of unmapped bits return 0.
- Read: avs_s0_readdata updates on the clock edge after avs_s0_read. It holds its value when no read is issued.
- Operand writes are always accepted, including while busy, and do not affect the running job.
- FSM states: IDLE, RUN.
  - IDLE: a CTRL write with start=1 in cycle T loads net_in from the operand registers and cnt from LATENCY, and sets state to RUN. It also clears done. All of this is visible in cycle T+1. net_in_valid=1 in T+1 only.
  - RUN: if cnt==0, capture net_out into the result registers, increment job_count (8-bit, wraps 255->0), set done, go to IDLE. Otherwise decrement cnt.
  - Result: busy=1 in cycles T+1..T+1+LATENCY. done=1 and results readable from T+2+LATENCY.
- LATENCY=0 means a combinational network; capture happens in T+1.
- LATENCY written during RUN takes effect at the next start only; cnt is already loaded.
- start while RUN: ignored, overrun set (sticky). net_in and cnt are unchanged.
- Simultaneous start and clear_done in IDLE: job launches and done=0. clear_done in the same cycle as capture: set wins, done=1.
- clear_err in the same cycle as a new overrun: set wins.
- net_in holds its value between jobs. net_out is sampled only at capture.
- Reset mid-RUN: job is aborted, no capture, all state returns to reset values immediately.

Decomposition:
- Package network_seq_pkg:
  - address constants ADDR_OPND0..ADDR_ID.
  - CTRL/STATUS bit indices.
  - typedef enum logic {IDLE, RUN} seq_state_t.
  - widths OPND_W=64, NET_IN_W=256, NET_OUT_W=128.
- Sub-module network_seq_csr: register file, address decode and registered readback. The top holds the FSM, counter and snapshot/capture.

Test Plan:
- Reset then read addresses 9, 14, 15 -> 0x0, DEFAULT_LATENCY, 0x4E455431. irq=0, net_in=0.
- Write a=1, b=2, c=3, d=4 (lo words), LATENCY=3, start at T -> net_in_valid only at T+1 with net_in={64'd1,64'd2,64'd3,64'd4}. busy T+1..T+4. Bench drives net_out={64'hA,64'hB} at T+4. Reads of 10 and 12 return 0xA and 0xB, STATUS=0x0102.
- LATENCY=0, start -> capture in T+1, done at T+2. Run 256 jobs -> job_count wraps to 0.
- Start during RUN -> overrun=1, timing of the first job unchanged. clear_err -> overrun=0.
- irq_en=1, job completes -> irq=1. Write CTRL clear_done -> irq=0 the next cycle. clear_done coincident with capture -> done stays 1.
- Assert reset mid-RUN (LATENCY=10, at cnt=5) -> busy=0 immediately, results stay 0. A later start runs normally.

Source files
------------

// File: rtl/network_job_sequencer_pkg.sv
// Shared constants and types for the runNetwork job sequencer.
package network_seq_pkg;

    localparam int unsigned OPND_W    = 64;
    localparam int unsigned NET_IN_W  = 256;
    localparam int unsigned NET_OUT_W = 128;

    localparam logic [3:0] ADDR_OPND0  = 4'd0;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_STATUS = 4'd9;
    localparam logic [3:0] ADDR_RES0   = 4'd10;
    localparam logic [3:0] ADDR_LAT    = 4'd14;
    localparam logic [3:0] ADDR_ID     = 4'd15;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_CLR_DONE = 1;
    localparam int unsigned CTRL_CLR_ERR  = 2;
    localparam int unsigned CTRL_IRQ_EN   = 3;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_OVERRUN = 2;
    localparam int unsigned STAT_JOB_LSB = 8;

    typedef enum logic {IDLE, RUN} seq_state_t;

endpackage

// File: rtl/network_job_sequencer_if.sv
// Avalon-MM slave bus for the job sequencer register window.
interface network_job_sequencer_if;
    logic [3:0]  avs_s0_address;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;

    modport master (
        output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        input  avs_s0_readdata
    );
    modport slave (
        input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata,
        output avs_s0_readdata
    );
endinterface

// File: rtl/network_job_sequencer_csr.sv
// Register file, write decode and registered readback for the job sequencer.
module network_seq_csr
    import network_seq_pkg::*;
#(
    parameter int unsigned DEFAULT_LATENCY = 0,
    parameter logic [31:0] BLOCK_ID        = 32'h4E45_5431
) (
    input  logic                 clk,
    input  logic                 reset,
    network_job_sequencer_if.slave avs,
    input  logic                 i_busy,
    input  logic                 i_done,
    input  logic                 i_overrun,
    input  logic [7:0]           i_job_count,
    input  logic [NET_OUT_W-1:0] i_result,
    output logic                 o_start,
    output logic                 o_clr_done,
    output logic                 o_clr_err,
    output logic [NET_IN_W-1:0]  o_operands,
    output logic [7:0]           o_latency,
    output logic                 o_irq_en
);

    logic [31:0] r_opnd [8];
    logic [7:0]  r_latency;
    logic        r_irq_en;
    logic [31:0] r_readdata;
    logic [31:0] w_rdata;
    logic        w_wr_ctrl;

    assign w_wr_ctrl  = avs.avs_s0_write && (avs.avs_s0_address == ADDR_CTRL);
    assign o_start    = w_wr_ctrl && avs.avs_s0_writedata[CTRL_START];
    assign o_clr_done = w_wr_ctrl && avs.avs_s0_writedata[CTRL_CLR_DONE];
    assign o_clr_err  = w_wr_ctrl && avs.avs_s0_writedata[CTRL_CLR_ERR];

    // Each 64-bit operand is {hi,lo}; net_in packs a in the top bits.
    assign o_operands = {r_opnd[1], r_opnd[0], r_opnd[3], r_opnd[2],
                         r_opnd[5], r_opnd[4], r_opnd[7], r_opnd[6]};
    assign o_latency  = r_latency;
    assign o_irq_en   = r_irq_en;
    assign avs.avs_s0_readdata = r_readdata;

    always_comb begin
        w_rdata = '0;
        if (avs.avs_s0_address < ADDR_CTRL) begin
            w_rdata = r_opnd[avs.avs_s0_address[2:0]];
        end else begin
            case (avs.avs_s0_address)
                ADDR_CTRL:         w_rdata[CTRL_IRQ_EN] = r_irq_en;
                ADDR_STATUS: begin
                    w_rdata[STAT_BUSY]                  = i_busy;
                    w_rdata[STAT_DONE]                  = i_done;
                    w_rdata[STAT_OVERRUN]               = i_overrun;
                    w_rdata[STAT_JOB_LSB +: 8]          = i_job_count;
                end
                ADDR_RES0:         w_rdata = i_result[95:64];
                ADDR_RES0 + 4'd1:  w_rdata = i_result[127:96];
                ADDR_RES0 + 4'd2:  w_rdata = i_result[31:0];
                ADDR_RES0 + 4'd3:  w_rdata = i_result[63:32];
                ADDR_LAT:          w_rdata[7:0] = r_latency;
                ADDR_ID:           w_rdata = BLOCK_ID;
                default:           w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 8; i++) r_opnd[i] <= '0;
            r_latency  <= 8'(DEFAULT_LATENCY);
            r_irq_en   <= 1'b0;
            r_readdata <= '0;
        end else begin
            if (avs.avs_s0_write) begin
                if (avs.avs_s0_address < ADDR_CTRL)
                    r_opnd[avs.avs_s0_address[2:0]] <= avs.avs_s0_writedata;
                if (avs.avs_s0_address == ADDR_CTRL)
                    r_irq_en <= avs.avs_s0_writedata[CTRL_IRQ_EN];
                if (avs.avs_s0_address == ADDR_LAT)
                    r_latency <= avs.avs_s0_writedata[7:0];
            end
            if (avs.avs_s0_read)
                r_readdata <= w_rdata;
        end
    end

endmodule

// File: rtl/network_job_sequencer.sv
// Job sequencer top: launch FSM, latency counter, operand snapshot and result capture.
module network_job_sequencer
    import network_seq_pkg::*;
#(
    parameter int unsigned DEFAULT_LATENCY = 0,
    parameter logic [31:0] BLOCK_ID        = 32'h4E45_5431
) (
    input  logic                   clk,
    input  logic                   reset,
    network_job_sequencer_if.slave avs,
    output logic [NET_IN_W-1:0]    net_in,
    output logic                   net_in_valid,
    input  logic [NET_OUT_W-1:0]   net_out,
    output logic                   irq
);

    seq_state_t           r_state;
    logic [7:0]           r_cnt;
    logic [NET_IN_W-1:0]  r_net_in;
    logic                 r_net_in_valid;
    logic [NET_OUT_W-1:0] r_result;
    logic                 r_done;
    logic                 r_overrun;
    logic [7:0]           r_job_count;

    logic                 w_start;
    logic                 w_clr_done;
    logic                 w_clr_err;
    logic [NET_IN_W-1:0]  w_operands;
    logic [7:0]           w_latency;
    logic                 w_irq_en;

    network_seq_csr #(
        .DEFAULT_LATENCY (DEFAULT_LATENCY),
        .BLOCK_ID        (BLOCK_ID)
    ) u_csr (
        .clk         (clk),
        .reset       (reset),
        .avs         (avs),
        .i_busy      (r_state == RUN),
        .i_done      (r_done),
        .i_overrun   (r_overrun),
        .i_job_count (r_job_count),
        .i_result    (r_result),
        .o_start     (w_start),
        .o_clr_done  (w_clr_done),
        .o_clr_err   (w_clr_err),
        .o_operands  (w_operands),
        .o_latency   (w_latency),
        .o_irq_en    (w_irq_en)
    );

    assign net_in       = r_net_in;
    assign net_in_valid = r_net_in_valid;
    assign irq          = r_done & w_irq_en;

    // Clears are applied first so later set assignments take priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_net_in       <= '0;
            r_net_in_valid <= 1'b0;
            r_result       <= '0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
            r_job_count    <= '0;
        end else begin
            r_net_in_valid <= 1'b0;
            if (w_clr_done) r_done    <= 1'b0;
            if (w_clr_err)  r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state        <= RUN;
                        r_net_in       <= w_operands;
                        r_cnt          <= w_latency;
                        r_net_in_valid <= 1'b1;
                        r_done         <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_start) r_overrun <= 1'b1;
                    if (r_cnt == 8'd0) begin
                        r_result    <= net_out;
                        r_job_count <= r_job_count + 8'd1;
                        r_done      <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_network_job_sequencer.sv
// Directed bench for network_job_sequencer: register vector table plus job timing sequences.
module tb_network_job_sequencer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] net_in;
    logic         net_in_valid;
    logic [127:0] net_out = '0;
    logic         irq;
    int           ncomp = 0;
    int           nfail = 0;

    network_job_sequencer_if bus();

    network_job_sequencer #(
        .DEFAULT_LATENCY (0),
        .BLOCK_ID        (32'h4E45_5431)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs          (bus),
        .net_in       (net_in),
        .net_in_valid (net_in_valid),
        .net_out      (net_out),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one bus cycle starting at the falling edge.
    task automatic step(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avs_s0_write     = w;
        bus.avs_s0_read      = r;
        bus.avs_s0_address   = a;
        bus.avs_s0_writedata = d;
    endtask

    task automatic rdchk(input string name, input logic [3:0] a, input logic [31:0] exp);
        step(0, 1, a, 32'd0);
        step(0, 0, 4'd0, 32'd0);
        chk(name, {224'd0, bus.avs_s0_readdata}, {224'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'd0,  1'b1, 32'd1,           32'd0};
        vecs[1]  = '{4'd2,  1'b1, 32'd2,           32'd0};
        vecs[2]  = '{4'd4,  1'b1, 32'd3,           32'd0};
        vecs[3]  = '{4'd6,  1'b1, 32'd4,           32'd0};
        vecs[4]  = '{4'd0,  1'b0, 32'd0,           32'd1};
        vecs[5]  = '{4'd2,  1'b0, 32'd0,           32'd2};
        vecs[6]  = '{4'd4,  1'b0, 32'd0,           32'd3};
        vecs[7]  = '{4'd6,  1'b0, 32'd0,           32'd4};
        vecs[8]  = '{4'd7,  1'b1, 32'h1234_5678,   32'd0};
        vecs[9]  = '{4'd7,  1'b0, 32'd0,           32'h1234_5678};
        vecs[10] = '{4'd7,  1'b1, 32'd0,           32'd0};
        vecs[11] = '{4'd14, 1'b1, 32'hFFFF_FF03,   32'd0};
        vecs[12] = '{4'd14, 1'b0, 32'd0,           32'h0000_0003};
        vecs[13] = '{4'd15, 1'b1, 32'd0,           32'd0};
        vecs[14] = '{4'd15, 1'b0, 32'd0,           32'h4E45_5431};
        vecs[15] = '{4'd10, 1'b1, 32'h55,          32'd0};
        vecs[16] = '{4'd10, 1'b0, 32'd0,           32'd0};
        vecs[17] = '{4'd8,  1'b1, 32'h8,           32'd0};
        vecs[18] = '{4'd8,  1'b0, 32'd0,           32'h8};
        vecs[19] = '{4'd8,  1'b1, 32'h0,           32'd0};

        bus.avs_s0_write = 0; bus.avs_s0_read = 0;
        bus.avs_s0_address = '0; bus.avs_s0_writedata = '0;
        repeat (3) @(negedge clk);
        chk("rst_irq", {255'd0, irq}, 256'd0);
        chk("rst_net_in", net_in, 256'd0);
        chk("rst_valid", {255'd0, net_in_valid}, 256'd0);
        reset = 1'b1;
        rdchk("rst_status", 4'd9, 32'd0);
        rdchk("rst_latency", 4'd14, 32'd0);
        rdchk("rst_id", 4'd15, 32'h4E45_5431);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].wr) step(1, 0, vecs[i].addr, vecs[i].wdata);
            else rdchk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        rdchk("ctrl_cleared", 4'd8, 32'd0);

        // LATENCY=3 job: busy T+1..T+4, capture of net_out driven at T+4.
        step(1, 0, 4'd8, 32'd1);
        step(0, 1, 4'd9, 32'd0);
        chk("j1_valid", {255'd0, net_in_valid}, 256'd1);
        chk("j1_net_in", net_in, {64'd1, 64'd2, 64'd3, 64'd4});
        for (int k = 2; k <= 5; k++) begin
            step(0, 1, 4'd9, 32'd0);
            if (k == 4) net_out = {64'hA, 64'hB};
            chk($sformatf("j1_busy_T%0d", k - 1), {224'd0, bus.avs_s0_readdata}, 256'h001);
            chk($sformatf("j1_valid_T%0d", k), {255'd0, net_in_valid}, 256'd0);
        end
        step(0, 1, 4'd10, 32'd0);
        chk("j1_status_done", {224'd0, bus.avs_s0_readdata}, 256'h0102);
        step(0, 1, 4'd12, 32'd0);
        chk("j1_e_lo", {224'd0, bus.avs_s0_readdata}, 256'hA);
        step(0, 0, 4'd0, 32'd0);
        chk("j1_f_lo", {224'd0, bus.avs_s0_readdata}, 256'hB);
        chk("j1_irq_off", {255'd0, irq}, 256'd0);

        // Operand write and second start while busy.
        step(1, 0, 4'd8, 32'd1);
        step(1, 0, 4'd0, 32'h99);
        chk("j2_valid", {255'd0, net_in_valid}, 256'd1);
        step(1, 0, 4'd8, 32'd1);
        step(0, 1, 4'd9, 32'd0);
        step(0, 1, 4'd9, 32'd0);
        chk("j2_ovr_T3", {224'd0, bus.avs_s0_readdata}, 256'h0105);
        chk("j2_net_in_held", net_in, {64'd1, 64'd2, 64'd3, 64'd4});
        chk("j2_no_relaunch", {255'd0, net_in_valid}, 256'd0);
        step(0, 1, 4'd9, 32'd0);
        chk("j2_ovr_T4", {224'd0, bus.avs_s0_readdata}, 256'h0105);
        step(0, 0, 4'd0, 32'd0);
        chk("j2_done_T5", {224'd0, bus.avs_s0_readdata}, 256'h0206);
        step(1, 0, 4'd8, 32'd4);
        rdchk("clr_err", 4'd9, 32'h0202);
        rdchk("opnd_busy_write", 4'd0, 32'h99);
        step(1, 0, 4'd0, 32'd1);

        // LATENCY=0: capture in T+1, done at T+2; then wrap job_count.
        step(1, 0, 4'd14, 32'd0);
        step(1, 0, 4'd8, 32'd1);
        step(0, 1, 4'd9, 32'd0);
        chk("l0_valid", {255'd0, net_in_valid}, 256'd1);
        step(0, 1, 4'd9, 32'd0);
        chk("l0_busy_T1", {224'd0, bus.avs_s0_readdata}, 256'h0201);
        step(0, 0, 4'd0, 32'd0);
        chk("l0_done_T2", {224'd0, bus.avs_s0_readdata}, 256'h0302);
        for (int j = 0; j < 253; j++) begin
            step(1, 0, 4'd8, 32'd1);
            step(0, 0, 4'd0, 32'd0);
        end
        rdchk("jobcnt_wrap", 4'd9, 32'h0002);

        // irq level follows done while irq_en is set.
        step(1, 0, 4'd8, 32'h9);
        step(0, 0, 4'd0, 32'd0);
        chk("irq_T1", {255'd0, irq}, 256'd0);
        step(0, 0, 4'd0, 32'd0);
        chk("irq_set", {255'd0, irq}, 256'd1);
        step(1, 0, 4'd8, 32'hA);
        step(0, 0, 4'd0, 32'd0);
        chk("irq_cleared", {255'd0, irq}, 256'd0);
        step(1, 0, 4'd8, 32'h9);
        step(1, 0, 4'd8, 32'hA);
        step(0, 1, 4'd9, 32'd0);
        step(0, 0, 4'd0, 32'd0);
        chk("clr_vs_capture_irq", {255'd0, irq}, 256'd1);
        chk("clr_vs_capture_st", {224'd0, bus.avs_s0_readdata}, 256'h0202);
        step(1, 0, 4'd8, 32'hB);
        step(0, 1, 4'd9, 32'd0);
        chk("start_clr_irq", {255'd0, irq}, 256'd0);
        step(0, 0, 4'd0, 32'd0);
        chk("start_clr_st", {224'd0, bus.avs_s0_readdata}, 256'h0201);
        step(1, 0, 4'd8, 32'h2);

        // Reset while counting down from LATENCY=10.
        step(1, 0, 4'd14, 32'd10);
        net_out = {64'hC, 64'hD};
        step(1, 0, 4'd8, 32'd1);
        repeat (5) step(0, 0, 4'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_net_in", net_in, 256'd0);
        chk("mid_rst_valid", {255'd0, net_in_valid}, 256'd0);
        chk("mid_rst_rdata", {224'd0, bus.avs_s0_readdata}, 256'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) step(0, 0, 4'd0, 32'd0);
        rdchk("post_rst_status", 4'd9, 32'd0);
        rdchk("post_rst_e_lo", 4'd10, 32'd0);
        rdchk("post_rst_f_lo", 4'd12, 32'd0);
        rdchk("post_rst_lat", 4'd14, 32'd0);

        step(1, 0, 4'd0, 32'd7);
        step(1, 0, 4'd14, 32'd1);
        net_out = {64'h11, 64'h0000_0005_0000_0006};
        step(1, 0, 4'd8, 32'd1);
        step(0, 0, 4'd0, 32'd0);
        chk("rerun_valid", {255'd0, net_in_valid}, 256'd1);
        chk("rerun_net_in", net_in, {64'd7, 192'd0});
        step(0, 1, 4'd9, 32'd0);
        step(0, 1, 4'd9, 32'd0);
        chk("rerun_busy", {224'd0, bus.avs_s0_readdata}, 256'h001);
        step(0, 1, 4'd13, 32'd0);
        chk("rerun_done", {224'd0, bus.avs_s0_readdata}, 256'h0102);
        step(0, 0, 4'd0, 32'd0);
        chk("rerun_f_hi", {224'd0, bus.avs_s0_readdata}, 256'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
